// File: rtl/fxp_divider.sv
// fxp_divider: multi-cycle unsigned fixed-point divider.
// Computes Q = (A << FRAC) / B by restoring division, one quotient bit per
// clock, behind a start/ready/valid handshake. Quotients too large for WIDTH
// bits saturate to all ones (ovf); a zero divisor yields all ones with dz set.
module fxp_divider #(
    parameter int WIDTH = 6,
    parameter int FRAC  = 3
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             ovf,
    output logic             dz
);

    // Number of restoring iterations: one per bit of the widened dividend.
    localparam int N     = WIDTH + FRAC;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // The dividend and quotient share one N-bit shift register: each
    // iteration consumes the dividend MSB and shifts a quotient bit into the
    // LSB, so after N iterations the register holds the full quotient.
    logic [N-1:0]     r_dq;
    logic [WIDTH-1:0] r_divisor;
    // Stored remainder is always below the divisor, so WIDTH bits suffice;
    // the WIDTH+1-bit working value exists only after the shift.
    logic [WIDTH-1:0] r_rem;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_ovf;
    logic             r_dz;

    logic [WIDTH:0]   w_rem_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_sub;
    logic [WIDTH-1:0] w_rem_next;
    logic [N-1:0]     w_dq_next;
    logic             w_last;
    logic             w_div_zero;
    logic             w_ovf_next;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        w_rem_shift = {r_rem, r_dq[N-1]};
        w_ge        = (w_rem_shift >= {1'b0, r_divisor});
        // The true difference is below the divisor, so modulo-2^WIDTH
        // subtraction on the low bits is exact.
        w_rem_sub   = w_rem_shift[WIDTH-1:0] - r_divisor;
        w_rem_next  = w_ge ? w_rem_sub : w_rem_shift[WIDTH-1:0];
        w_dq_next   = {r_dq[N-2:0], w_ge};
        w_last      = (r_cnt == LAST_IT);
        w_div_zero  = (r_divisor == '0);
        w_ovf_next  = |w_dq_next[N-1 -: FRAC];
    end

    // State register.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake outputs decoded from the state.
    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        valid        = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                // A zero divisor spends a single CALC cycle, then reports.
                if (w_div_zero || w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                valid        = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: latch operands on accept, iterate in CALC, publish results
    // on the edge that enters DONE.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_dq      <= '0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_q       <= '0;
            r_r       <= '0;
            r_ovf     <= 1'b0;
            r_dz      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dq      <= {A, {FRAC{1'b0}}};
                        r_divisor <= B;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        r_q       <= '0;
                        r_r       <= '0;
                        r_ovf     <= 1'b0;
                        r_dz      <= 1'b0;
                    end
                end
                S_CALC: begin
                    if (w_div_zero) begin
                        r_q   <= {WIDTH{1'b1}};
                        r_r   <= '0;
                        r_ovf <= 1'b0;
                        r_dz  <= 1'b1;
                    end else begin
                        r_rem <= w_rem_next;
                        r_dq  <= w_dq_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_q   <= w_ovf_next ? {WIDTH{1'b1}} : w_dq_next[WIDTH-1:0];
                            r_r   <= w_rem_next;
                            r_ovf <= w_ovf_next;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Q   = r_q;
    assign R   = r_r;
    assign ovf = r_ovf;
    assign dz  = r_dz;

endmodule

// File: tb/tb_fxp_divider.sv
// Testbench for fxp_divider: directed vectors with literal expectations plus
// randomized traffic, all checked every cycle against an arithmetic model.
module tb_fxp_divider;

    localparam int WIDTH = 6;
    localparam int FRAC  = 3;
    localparam int N     = WIDTH + FRAC;

    logic             clk = 1'b0;
    logic             reset_l;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             ovf;
    logic             dz;

    fxp_divider #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .start   (start),
        .A       (A),
        .B       (B),
        .ready   (ready),
        .valid   (valid),
        .Q       (Q),
        .R       (R),
        .ovf     (ovf),
        .dz      (dz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    bit cmp_en   = 0;

    // Behavioural model: edge numbers of the pending acceptance/result and
    // the first edge at which a new start will be accepted.
    int m_acc_edge  = -1;
    int m_val_edge  = -1;
    int m_free_edge = 0;
    int m_res_q, m_res_r, m_res_ovf, m_res_dz;
    int m_q = 0, m_r = 0, m_ovf = 0, m_dz = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d edge=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_accept(input int e, input int a, input int b);
        int num, qq;
        num        = a * (1 << FRAC);
        m_acc_edge = e;
        if (b == 0) begin
            m_res_q = (1 << WIDTH) - 1; m_res_r = 0; m_res_ovf = 0; m_res_dz = 1;
            m_val_edge  = e + 1;
            m_free_edge = e + 3;
        end else begin
            qq = num / b;
            m_res_r  = num % b;
            m_res_dz = 0;
            if (qq > (1 << WIDTH) - 1) begin
                m_res_q = (1 << WIDTH) - 1; m_res_ovf = 1;
            end else begin
                m_res_q = qq; m_res_ovf = 0;
            end
            m_val_edge  = e + N;
            m_free_edge = e + N + 2;
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_r = 0; m_ovf = 0; m_dz = 0;
        m_acc_edge = -1; m_val_edge = -1; m_free_edge = 0;
    endtask

    // Called at a falling edge: drive one cycle of stimulus, return at the next falling edge.
    task automatic drive_cycle(input bit go, input int a, input int b);
        A = WIDTH'(a);
        B = WIDTH'(b);
        start = go;
        if (go && reset_l && (cyc + 1 >= m_free_edge)) model_accept(cyc + 1, a, b);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_free();
        @(negedge clk);
        while (cyc + 1 < m_free_edge) @(negedge clk);
    endtask

    task automatic wait_valid(output int ev, output bit found);
        found = 0;
        ev    = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (valid === 1'b1) begin
                found = 1;
                ev    = cyc;
                break;
            end
        end
        if (!found) chk("valid_timeout", 0, 1);
    endtask

    task automatic run_op(input string name, input int a, input int b, input int eq,
                          input int er, input int eovf, input int edz, input int elat);
        int acc, ev;
        bit found;
        wait_free();
        drive_cycle(1, a, b);
        acc = cyc;
        wait_valid(ev, found);
        if (found) begin
            $display("op %s A=%0d B=%0d -> Q=%0d R=%0d ovf=%0d dz=%0d latency=%0d",
                     name, a, b, Q, R, ovf, dz, ev - acc + 1);
            chk({name, "_latency"}, ev - acc + 1, elat);
            chk({name, "_Q"}, Q, eq);
            chk({name, "_R"}, R, er);
            chk({name, "_ovf"}, ovf, eovf);
            chk({name, "_dz"}, dz, edz);
            chk({name, "_ready_in_done"}, ready, 0);
        end
    endtask

    // Per-cycle compare against the model.
    initial begin
        int e;
        forever begin
            @(posedge clk); #1;
            if (cmp_en) begin
                e = cyc;
                if (e == m_acc_edge) begin
                    m_q = 0; m_r = 0; m_ovf = 0; m_dz = 0;
                end
                if (e == m_val_edge) begin
                    m_q = m_res_q; m_r = m_res_r; m_ovf = m_res_ovf; m_dz = m_res_dz;
                end
                if (valid === 1'b1) n_valid++;
                chk("cyc_ready", ready, (e + 1 >= m_free_edge) ? 1 : 0);
                chk("cyc_valid", valid, (e == m_val_edge) ? 1 : 0);
                chk("cyc_Q", Q, m_q);
                chk("cyc_R", R, m_r);
                chk("cyc_ovf", ovf, m_ovf);
                chk("cyc_dz", dz, m_dz);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, ev, v0;
        bit found;
        start   = 1'b0;
        A       = '0;
        B       = '0;
        reset_l = 1'b1;
        #1 reset_l = 1'b0;
        #2;
        chk("reset_ready", ready, 1);
        chk("reset_valid", valid, 0);
        chk("reset_Q", Q, 0);
        chk("reset_R", R, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_dz", dz, 0);
        @(negedge clk);
        @(negedge clk);
        reset_l = 1'b1;
        cmp_en  = 1;

        // Directed vectors with hand-computed results.
        run_op("div_2_by_half", 16, 4, 32, 0, 0, 0, 10);
        run_op("div_1_by_3", 8, 24, 2, 16, 0, 0, 10);
        run_op("div_1p5_by_3", 12, 24, 4, 0, 0, 0, 10);
        run_op("overflow", 63, 1, 63, 0, 1, 0, 10);
        run_op("div_zero", 5, 0, 63, 0, 0, 1, 2);
        run_op("after_dz", 16, 16, 8, 0, 0, 0, 10);

        // Starts during CALC (cycles 3 and 7) must be ignored.
        wait_free();
        drive_cycle(1, 16, 4);
        acc = cyc;
        v0  = n_valid;
        drive_cycle(0, 0, 0);
        drive_cycle(0, 0, 0);
        drive_cycle(1, 7, 9);
        drive_cycle(0, 30, 2);
        drive_cycle(0, 11, 0);
        drive_cycle(0, 0, 0);
        drive_cycle(1, 1, 2);
        wait_valid(ev, found);
        if (found) begin
            $display("op ignored_starts A=16 B=4 -> Q=%0d R=%0d latency=%0d", Q, R, ev - acc + 1);
            chk("ignored_latency", ev - acc + 1, 10);
            chk("ignored_Q", Q, 32);
        end
        @(negedge clk);
        for (int i = 0; i < 5; i++) drive_cycle(0, $urandom_range(0, 63), $urandom_range(0, 63));
        chk("ignored_one_valid", n_valid - v0, 1);
        chk("ignored_hold_Q", Q, 32);
        chk("ignored_hold_R", R, 0);
        chk("ignored_hold_dz", dz, 0);

        // Reset mid-CALC abandons the operation.
        wait_free();
        drive_cycle(1, 63, 5);
        drive_cycle(0, 0, 0);
        drive_cycle(0, 0, 0);
        drive_cycle(0, 0, 0);
        #2 reset_l = 1'b0;
        model_reset();
        #1;
        $display("op reset_mid_calc -> ready=%0d Q=%0d valid=%0d", ready, Q, valid);
        chk("midreset_ready", ready, 1);
        chk("midreset_Q", Q, 0);
        chk("midreset_valid", valid, 0);
        @(negedge clk);
        @(negedge clk);
        reset_l = 1'b1;
        v0 = n_valid;
        for (int i = 0; i < 15; i++) drive_cycle(0, 0, 0);
        chk("midreset_no_valid", n_valid - v0, 0);
        run_op("after_reset", 16, 4, 32, 0, 0, 0, 10);

        // Randomized traffic: sporadic starts, some while busy, some with B=0.
        @(negedge clk);
        for (int i = 0; i < 400; i++) begin
            int a, b;
            bit go;
            a  = $urandom_range(0, 63);
            b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63);
            go = ($urandom_range(0, 3) == 0);
            if (go && (cyc + 1 >= m_free_edge))
                $display("op random A=%0d B=%0d accepted at edge %0d", a, b, cyc + 1);
            drive_cycle(go, a, b);
        end
        wait_free();
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
